// File: rtl/msx_slot_pkg.sv
// Shared constants and helpers for the MSX primary/secondary slot decoder and
// memory mapper: the sub-slot register address, the mapper port base and reset segments.
package msx_slot_pkg;

    localparam logic [15:0] SSR_ADDR      = 16'hFFFF;
    localparam logic [7:0]  MAP_PORT_BASE = 8'hFC;

    // Mapper segments come out of reset as 3,2,1,0 so pages 0..3 see a flat 64 KB.
    localparam logic [7:0] SEG_RESET_0 = 8'd3;
    localparam logic [7:0] SEG_RESET_1 = 8'd2;
    localparam logic [7:0] SEG_RESET_2 = 8'd1;
    localparam logic [7:0] SEG_RESET_3 = 8'd0;

    function automatic logic [7:0] seg_reset_value(input logic [1:0] seg);
        case (seg)
            2'd0:    seg_reset_value = SEG_RESET_0;
            2'd1:    seg_reset_value = SEG_RESET_1;
            2'd2:    seg_reset_value = SEG_RESET_2;
            default: seg_reset_value = SEG_RESET_3;
        endcase
    endfunction

    // Pick the 2-bit field for a page out of a slot-style register (PPI port A or an SSR).
    function automatic logic [1:0] page_slot(input logic [7:0] slot_reg, input logic [1:0] page);
        case (page)
            2'd0:    page_slot = slot_reg[1:0];
            2'd1:    page_slot = slot_reg[3:2];
            2'd2:    page_slot = slot_reg[5:4];
            default: page_slot = slot_reg[7:6];
        endcase
    endfunction

endpackage

// File: rtl/msx_wr_strobe.sv
// Converts the Z80 write strobe into a single-cycle commit on its falling edge,
// so a long or stretched write updates a register exactly once.
module msx_wr_strobe (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_n,
    output logic commit
);

    logic wr_q_r;

    // Previous strobe level; resets low so a strobe already low at release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q_r <= 1'b0;
        end else begin
            wr_q_r <= wr_n;
        end
    end

    assign commit = wr_q_r & ~wr_n;

endmodule

// File: rtl/msx_slot_mapper.sv
// MSX slot decoder: primary slot selects from PPI port A, secondary slot registers
// at 0xFFFF for expanded slots, and the I/O 0xFC-0xFF memory mapper segment registers.
module msx_slot_mapper
    import msx_slot_pkg::*;
#(
    parameter int         NUM_SLOTS = 4,
    parameter logic [3:0] EXP_MASK  = 4'b1000,
    parameter int         SEG_BITS  = 3,
    parameter int         MAP_SLOT  = 3,
    parameter int         MAP_SUB   = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [15:0]            addr_i,
    input  logic [7:0]             data_i,
    input  logic                   mreq_n_i,
    input  logic                   iorq_n_i,
    input  logic                   rd_n_i,
    input  logic                   wr_n_i,
    input  logic                   m1_n_i,
    input  logic                   rfsh_n_i,
    input  logic [7:0]             psl_i,
    output logic [NUM_SLOTS-1:0]   sltsl_n_o,
    output logic [15:0]            subsl_n_o,
    output logic [SEG_BITS+13:0]   map_addr_o,
    output logic                   map_cs_n_o,
    output logic [7:0]             data_o,
    output logic                   data_oe_o
);

    localparam logic [3:0] SLOT_MASK   = 4'((5'd1 << NUM_SLOTS) - 5'd1);
    localparam logic [3:0] EXP_EFF     = EXP_MASK & SLOT_MASK;
    localparam logic [1:0] MAP_SUB_SEL = 2'(MAP_SUB);

    logic [7:0]          ssr_r [4];
    logic [SEG_BITS-1:0] seg_r [4];

    logic [1:0]  page_s;
    logic [1:0]  pslot_s;
    logic [7:0]  cur_ssr_s;
    logic [1:0]  sub_s;
    logic        slot_valid_s;
    logic        slot_exp_s;
    logic        mem_s;
    logic        conflict_s;
    logic        ssr_acc_s;
    logic        io_map_s;
    logic        commit_s;
    logic        ssr_we_s;
    logic        seg_we_s;
    logic [3:0]  slot_sel_s;
    logic [15:0] subsl_n_s;
    logic        map_cs_s;
    logic [7:0]  rdata_s;
    logic        rdata_oe_s;

    msx_wr_strobe u_wr_strobe (
        .clk    (clk_i),
        .rst_n  (reset_n_i),
        .wr_n   (wr_n_i),
        .commit (commit_s)
    );

    // Bus cycle classification for the current address and strobes.
    always_comb begin
        page_s       = addr_i[15:14];
        pslot_s      = page_slot(psl_i, page_s);
        cur_ssr_s    = ssr_r[pslot_s];
        sub_s        = page_slot(cur_ssr_s, page_s);
        slot_valid_s = SLOT_MASK[pslot_s];
        slot_exp_s   = EXP_EFF[pslot_s];
        mem_s        = ~mreq_n_i & rfsh_n_i;
        conflict_s   = ~mreq_n_i & ~iorq_n_i;
        ssr_acc_s    = mem_s & (addr_i == SSR_ADDR) & slot_exp_s;
        io_map_s     = ~iorq_n_i & m1_n_i & mreq_n_i & (addr_i[7:2] == MAP_PORT_BASE[7:2]);
        ssr_we_s     = commit_s & ssr_acc_s & ~conflict_s;
        seg_we_s     = commit_s & io_map_s & ~conflict_s;
    end

    // Primary slot select; an SSR access is claimed by the decoder itself.
    always_comb begin
        slot_sel_s = 4'b0000;
        if (mem_s && slot_valid_s && !ssr_acc_s) begin
            slot_sel_s[pslot_s] = 1'b1;
        end else begin
            slot_sel_s = 4'b0000;
        end
    end

    // Secondary slot selects, only for slots built as expanded.
    always_comb begin
        subsl_n_s = 16'hFFFF;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) begin
                if (EXP_EFF[s] && slot_sel_s[s] && (sub_s == 2'(k))) begin
                    subsl_n_s[4*s+k] = 1'b0;
                end else begin
                    subsl_n_s[4*s+k] = 1'b1;
                end
            end
        end
    end

    // Mapper RAM select follows its slot, and its sub-slot when that slot is expanded.
    always_comb begin
        map_cs_s = 1'b0;
        if (EXP_EFF[MAP_SLOT]) begin
            map_cs_s = slot_sel_s[MAP_SLOT] & (sub_s == MAP_SUB_SEL);
        end else begin
            map_cs_s = slot_sel_s[MAP_SLOT];
        end
    end

    // Register read-back mux; SSR reads return the complement as on real hardware.
    always_comb begin
        rdata_s    = 8'hFF;
        rdata_oe_s = 1'b0;
        if (rd_n_i || conflict_s) begin
            rdata_s    = 8'hFF;
            rdata_oe_s = 1'b0;
        end else if (ssr_acc_s) begin
            rdata_s    = ~cur_ssr_s;
            rdata_oe_s = 1'b1;
        end else if (io_map_s) begin
            rdata_s[SEG_BITS-1:0] = seg_r[addr_i[1:0]];
            rdata_oe_s            = 1'b1;
        end else begin
            rdata_s    = 8'hFF;
            rdata_oe_s = 1'b0;
        end
    end

    // Sub-slot and segment registers, loaded once per write strobe.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int s = 0; s < 4; s++) begin
                ssr_r[s] <= 8'h00;
                seg_r[s] <= SEG_BITS'(seg_reset_value(2'(s)));
            end
        end else begin
            if (ssr_we_s) begin
                ssr_r[pslot_s] <= data_i;
            end
            if (seg_we_s) begin
                seg_r[addr_i[1:0]] <= data_i[SEG_BITS-1:0];
            end
        end
    end

    assign sltsl_n_o  = ~slot_sel_s[NUM_SLOTS-1:0];
    assign subsl_n_o  = subsl_n_s;
    assign map_cs_n_o = ~map_cs_s;
    assign map_addr_o = {seg_r[page_s], addr_i[13:0]};
    assign data_o     = rdata_s;
    assign data_oe_o  = rdata_oe_s;

endmodule
